ps2_kb_receiver: RTL and testbench
==================================

// Module: ps2_kb_receiver
// PURPOSE
//  Receives PS/2 keyboard device-to-host frames and presents scan codes on Kb_Byte.
//  Sits directly upstream of the IO block, which samples Kb_Byte on its IO=2 path.
//  Synchronises and de-glitches the raw PS/2 lines into the Clock domain.
//  Validates each 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
//  Recovers from stalled frames with a timeout.
// PARAMETERS
//  SYNC_STAGES     2      flip-flop stages on PS2_Clk and PS2_Data (>=2)
//  FILTER_LEN      4      cycles the synchronised PS2_Clk must hold before its filtered level changes
//  TIMEOUT_CYCLES  10000  max Clock cycles between falling edges inside a frame (200 us at 50 MHz)
// PORTS
//  Clock        in   1  system clock (the IO block's Fast_Clock); all logic uses the rising edge
//  Reset        in   1  reset, asynchronous, active-high
//  PS2_Clk      in   1  raw PS/2 clock, asynchronous
//  PS2_Data     in   1  raw PS/2 data, asynchronous
//  Kb_Byte      out  8  last accepted scan code; holds until the next accepted one
//  Kb_Valid     out  1  one-cycle pulse when Kb_Byte updates
//  Kb_Error     out  1  one-cycle pulse on a start, parity, stop or timeout error
//  Kb_Busy      out  1  high while the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: Kb_Byte=8'h00, Kb_Valid=0, Kb_Error=0, Kb_Busy=0, FSM=IDLE.
//  Reset values also apply to counters, shift register and synchronisers (filtered clock = 1).
//  Filtering:
//   - Filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
//   - Fall = filtered clock goes 1->0; it is a one-cycle strobe.
//   - PS2_Data is sampled from its synchroniser output in the cycle that Fall is high.
//  FSM, advancing only on Fall:
//   - IDLE: data=0 -> DATA, bit count=0. Data=1 -> stay in IDLE, pulse Kb_Error.
//   - DATA: shift the bit in LSB first. Go to PARITY after the 8th bit.
//   - PARITY: store the parity bit, then go to STOP.
//   - STOP: data=1 and odd parity over data+parity -> accept the byte.
//     Otherwise pulse Kb_Error. Either way, return to IDLE.
//  Accept: Kb_Byte and Kb_Valid update in the cycle after the Fall that samples the stop bit.
//   Latency from the raw PS2_Clk falling edge is SYNC_STAGES+FILTER_LEN+1 cycles (7 at defaults).
//  Error: Kb_Byte keeps its previous value; the error pulse is one cycle after the Fall.
//  Timeout:
//   - The counter is cleared on every Fall and counts while not in IDLE.
//   - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse Kb_Error, discard partial bits.
//   - If a Fall and the timeout occur in the same cycle, the Fall wins.
//  Reset mid-frame aborts the frame and produces no Kb_Valid or Kb_Error.
//  Kb_Valid and Kb_Error are never high together.
//  Host-to-device transmission is not supported; both lines are input only.
// CONFIGURATION
//  PS2_BREAK_FILTER_EN defined:
//   - A valid 8'hF0 sets break_pending; Kb_Byte is unchanged and there is no Kb_Valid.
//   - The next valid byte clears break_pending, sets Kb_Byte=8'h00 (key released), pulses Kb_Valid.
//   - A frame error or timeout while break_pending is set clears break_pending.
//   - Reset clears break_pending.
//  PS2_BREAK_FILTER_EN undefined:
//   - Every valid byte, including 8'hF0, drives Kb_Byte and pulses Kb_Valid.
//   - No break_pending register exists.
// TESTING
//  1. Frame 8'h1C (A make) with parity 0, 10 kHz PS2_Clk -> Kb_Byte=8'h1C;
//     one Kb_Valid 7 cycles after the stop-bit edge.
//  2. Frame 8'h1C with parity 1 -> one Kb_Error pulse; Kb_Byte holds its previous value; FSM returns to IDLE.
//  3. Stop PS2_Clk after 4 data bits for TIMEOUT_CYCLES+5 -> Kb_Error pulse, Kb_Busy=0;
//     a following frame 8'h32 is accepted.
//  4. Insert 2-cycle low glitches on PS2_Clk while idle -> no state change, no pulses.
//  5. Send F0 then 1C: with the macro, Kb_Byte goes 1C->00 with one Kb_Valid;
//     without the macro, Kb_Byte=F0 then 1C with two Kb_Valid pulses.
//  6. Assert Reset after 6 bits of a frame -> all outputs at reset values, no pulses;
//     a following frame 8'h45 is accepted.

Source files
------------

// File: rtl/ps2_kb_receiver.sv
`default_nettype none
// ==========================================================================
// ps2_kb_receiver : PS/2 keyboard device-to-host frame receiver (sync, filter, FSM)
// Optional PS2_BREAK_FILTER_EN: F0-prefixed break codes are reported as 8'h00
// Revision 1.0
// ==========================================================================
module ps2_kb_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_Clk,
  input  logic       PS2_Data,
  output logic [7:0] Kb_Byte,
  output logic       Kb_Valid,
  output logic       Kb_Error,
  output logic       Kb_Busy
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   filt_q, fall_q;
  logic [FCW-1:0]         fcnt_q;
  logic                   w_clk_s, w_dat_s;

  assign w_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign w_dat_s = dat_sync_q[SYNC_STAGES-1];

  // Idle PS/2 lines are high, so synchronisers and filter reset to 1.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_Clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_Data};
      fall_q     <= 1'b0;
      if (w_clk_s == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= w_clk_s;
        fcnt_q <= '0;
        fall_q <= ~w_clk_s;
      end else begin
        fcnt_q <= fcnt_q + FCW'(1);
      end
    end
  end

  logic [1:0]     state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic           par_q, par_d;
  logic [TCW-1:0] to_q, to_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           w_timeout;
`ifdef PS2_BREAK_FILTER_EN
  logic           bp_q, bp_d;
`endif

  // A Fall in the same cycle always takes priority over the timeout.
  assign w_timeout = (state_q != c_IDLE) && !fall_q && (to_q == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= c_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      bp_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      to_q    <= to_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef PS2_BREAK_FILTER_EN
      bp_q    <= bp_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (fall_q) begin
      case (state_q)
        c_IDLE:   if (!w_dat_s) state_d = c_DATA;
        c_DATA:   if (bcnt_q == 3'd7) state_d = c_PARITY;
        c_PARITY: state_d = c_STOP;
        default:  state_d = c_IDLE;
      endcase
    end else if (w_timeout) begin
      state_d = c_IDLE;
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    to_d    = (fall_q || state_q == c_IDLE) ? '0 : to_q + TCW'(1);
`ifdef PS2_BREAK_FILTER_EN
    bp_d    = bp_q;
`endif
    if (fall_q) begin
      case (state_q)
        c_IDLE: begin
          if (!w_dat_s) begin
            shift_d = '0;
            bcnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        c_DATA: begin
          shift_d = {w_dat_s, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
        end
        c_PARITY: par_d = w_dat_s;
        default: begin
          if (w_dat_s && (^{shift_q, par_q})) begin
`ifdef PS2_BREAK_FILTER_EN
            if (shift_q == 8'hF0 && !bp_q) begin
              bp_d = 1'b1;
            end else if (bp_q) begin
              bp_d    = 1'b0;
              byte_d  = 8'h00;
              valid_d = 1'b1;
            end else begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            byte_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            bp_d  = 1'b0;
`endif
          end
        end
      endcase
    end else if (w_timeout) begin
      err_d   = 1'b1;
      shift_d = '0;
      bcnt_d  = '0;
      to_d    = '0;
`ifdef PS2_BREAK_FILTER_EN
      bp_d    = 1'b0;
`endif
    end
  end

  assign Kb_Byte  = byte_q;
  assign Kb_Valid = valid_q;
  assign Kb_Error = err_q;
  assign Kb_Busy  = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_receiver.sv
`default_nettype none
// ==========================================================================
// tb_ps2_kb_receiver : scoreboard bench for ps2_kb_receiver (directed frames)
// Revision 1.0
// ==========================================================================
module tb_ps2_kb_receiver;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 300;
  localparam int LAT     = 7;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_Clk = 1'b1;
  logic       PS2_Data = 1'b1;
  logic [7:0] Kb_Byte;
  logic       Kb_Valid, Kb_Error, Kb_Busy;

  ps2_kb_receiver #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .PS2_Clk (PS2_Clk),
    .PS2_Data(PS2_Data),
    .Kb_Byte (Kb_Byte),
    .Kb_Valid(Kb_Valid),
    .Kb_Error(Kb_Error),
    .Kb_Busy (Kb_Busy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] bval;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] exp_byte = 8'h00;
  bit         bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_err, input logic [7:0] b, input int c);
    exp_t e;
    e.is_err = is_err;
    e.bval   = b;
    e.cyc    = c;
    q.push_back(e);
  endtask

  // Reference outcome of a complete frame, evaluated at the stop-bit fall.
  task automatic expect_stop(input logic [7:0] b, input logic par, input logic stop);
    if (stop && ((^b) ^ par)) begin
`ifdef PS2_BREAK_FILTER_EN
      if (bp) begin
        bp = 1'b0;
        exp_byte = 8'h00;
        push(1'b0, exp_byte, cyc + LAT);
      end else if (b == 8'hF0) begin
        bp = 1'b1;
      end else begin
        exp_byte = b;
        push(1'b0, exp_byte, cyc + LAT);
      end
`else
      exp_byte = b;
      push(1'b0, exp_byte, cyc + LAT);
`endif
    end else begin
      bp = 1'b0;
      push(1'b1, exp_byte, cyc + LAT);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop_bit,
                            input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ flip_par;
    bits = {stop_bit, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clock);
      PS2_Data = bits[i];
      repeat (HALF) @(negedge Clock);
      PS2_Clk = 1'b0;
      if (i == 10) expect_stop(b, par, stop_bit);
      repeat (HALF) @(negedge Clock);
      PS2_Clk = 1'b1;
    end
    @(negedge Clock);
    PS2_Data = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every output pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (Kb_Valid || Kb_Error) begin
        check("valid_error_exclusive", {31'd0, Kb_Valid & Kb_Error}, 32'd0);
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b error=%0b byte=%0h, required no pulse",
                   Kb_Valid, Kb_Error, Kb_Byte);
        end else begin
          e = q.pop_front();
          check("pulse_kind_is_error", {31'd0, Kb_Error}, {31'd0, e.is_err});
          check("kb_byte", {24'd0, Kb_Byte}, {24'd0, e.bval});
          if (e.cyc >= 0) check("pulse_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(5);
    check("reset_kb_byte", {24'd0, Kb_Byte}, 32'h00);
    check("reset_kb_valid", {31'd0, Kb_Valid}, 32'd0);
    check("reset_kb_error", {31'd0, Kb_Error}, 32'd0);
    check("reset_kb_busy", {31'd0, Kb_Busy}, 32'd0);
    Reset = 1'b0;
    idle(10);

    send_frame(8'h1C, 1'b0, 1'b1, 11);
    idle(30);
    check("busy_after_1c", {31'd0, Kb_Busy}, 32'd0);

    send_frame(8'h1C, 1'b1, 1'b1, 11);
    idle(30);
    check("busy_after_parity_err", {31'd0, Kb_Busy}, 32'd0);

    // Start bit high: error from IDLE.
    @(negedge Clock);
    PS2_Data = 1'b1;
    repeat (HALF) @(negedge Clock);
    PS2_Clk = 1'b0;
    push(1'b1, exp_byte, cyc + LAT);
    repeat (HALF) @(negedge Clock);
    PS2_Clk = 1'b1;
    idle(30);
    check("busy_after_start_err", {31'd0, Kb_Busy}, 32'd0);

    send_frame(8'h32, 1'b0, 1'b0, 11);
    idle(30);

    // Stall after 4 data bits.
    send_frame(8'h32, 1'b0, 1'b1, 5);
    check("busy_mid_frame", {31'd0, Kb_Busy}, 32'd1);
    push(1'b1, exp_byte, -1);
    idle(TIMEOUT + 5);
    check("busy_after_timeout", {31'd0, Kb_Busy}, 32'd0);
    check("timeout_error_seen", q.size(), 32'd0);
    send_frame(8'h32, 1'b0, 1'b1, 11);
    idle(30);

    for (int g = 0; g < 3; g++) begin
      @(negedge Clock);
      PS2_Clk = 1'b0;
      idle(2);
      PS2_Clk = 1'b1;
      idle(10);
    end
    check("busy_after_glitches", {31'd0, Kb_Busy}, 32'd0);
    check("byte_after_glitches", {24'd0, Kb_Byte}, 32'h32);

    send_frame(8'hF0, 1'b0, 1'b1, 11);
    idle(30);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    idle(30);

    send_frame(8'h45, 1'b0, 1'b1, 6);
    @(negedge Clock);
    #1 Reset = 1'b1;
    exp_byte = 8'h00;
    bp = 1'b0;
    #1;
    check("midreset_kb_byte", {24'd0, Kb_Byte}, 32'h00);
    check("midreset_kb_valid", {31'd0, Kb_Valid}, 32'd0);
    check("midreset_kb_error", {31'd0, Kb_Error}, 32'd0);
    check("midreset_kb_busy", {31'd0, Kb_Busy}, 32'd0);
    idle(4);
    Reset = 1'b0;
    idle(10);
    send_frame(8'h45, 1'b0, 1'b1, 11);
    idle(30);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
